// File: rtl/lstm_pkg.sv
// lstm_pkg
// Shared definitions for the LSTM datapath blocks (address generators,
// fetch stages, gate MAC).
//   lstm_state_e    : sequencing state encoding (IDLE / FETCH / DRAIN)
//   LSTM_ADDR_WIDTH : default hidden-state RAM address width
//   LSTM_DATA_WIDTH : default hidden-state word width (fixed-point)
package lstm_pkg;

    localparam int LSTM_ADDR_WIDTH = 12;
    localparam int LSTM_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } lstm_state_e;

endpackage

// File: rtl/lstm_sync_fifo.sv
// lstm_sync_fifo
// Single-clock show-ahead FIFO. The head entry is presented on rdata
// whenever empty is low; pop advances past it. Push and pop may occur in
// the same cycle at any fill level. There is no bypass: a word pushed into
// an empty FIFO becomes visible the following cycle.
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset (flushes the FIFO)
//   push  : write wdata at the tail
//   wdata : write data
//   pop   : discard the head entry (ignored while empty)
//   rdata : head entry
//   empty : no entries stored
//   count : number of stored entries
module lstm_sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_eff;
    logic             full;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign pop_eff = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_eff)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop_eff)
                count <= count + 1'b1;
            else if (!push && pop_eff)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wdata;
    end

    // The upstream credit scheme must never push into a full FIFO.
    no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && full && !pop_eff));

endmodule

// File: rtl/lstm_h_fetch.sv
// lstm_h_fetch
// Fetch stage behind the hidden-state address generator. Each pass enables
// the generator LEN times, turns each address into a synchronous RAM read
// and queues the returned words for the gate MAC on a valid/ready stream.
// Issue is credit-limited (FIFO entries + read in flight) so the output
// buffer cannot overflow under downstream back-pressure.
//   clk          : clock, rising edge
//   rst          : asynchronous active-low reset
//   i_start      : one-cycle pulse, begins a pass (ignored while busy)
//   o_gen_en     : advance the address generator
//   i_addr       : current generator address
//   o_mem_rd_en  : RAM read strobe
//   o_mem_addr   : RAM read address
//   i_mem_rdata  : RAM data, one cycle after the read strobe
//   o_valid      : output word available
//   i_ready      : downstream accepts
//   o_data       : output word
//   o_last       : head word is the LEN-th word of the pass
//   o_busy       : pass in progress
//   o_done       : one-cycle pulse after the last word is accepted
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for i_start
// ST_FETCH | issuing reads until LEN have been issued
// ST_DRAIN | all reads issued; waiting for the last word to be accepted
module lstm_h_fetch
    import lstm_pkg::*;
#(
    parameter int ADDR_WIDTH = LSTM_ADDR_WIDTH,
    parameter int DATA_WIDTH = LSTM_DATA_WIDTH,
    parameter int LEN        = 372,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    output logic                  o_gen_en,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  o_mem_rd_en,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int CW  = $clog2(LEN + 1);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] LEN_C = CW'(LEN);

    lstm_state_e     state;
    logic [CW-1:0]   issued;
    logic [CW-1:0]   delivered;
    logic            inflight;
    logic            issue;
    logic [FCW-1:0]  fifo_count;
    logic [FCW:0]    occupancy;
    logic            fifo_empty;
    logic [DATA_WIDTH:0] fifo_head;
    logic            push_last;
    logic            handshake;

    // Credit: a read in flight has already claimed a FIFO slot.
    assign occupancy = {1'b0, fifo_count} + {{FCW{1'b0}}, inflight};
    assign issue     = (state == ST_FETCH) && (issued < LEN_C)
                    && (occupancy < (FCW+1)'(FIFO_DEPTH));

    assign o_gen_en    = issue;
    assign o_mem_rd_en = issue;
    assign o_mem_addr  = i_addr;

    // delivered counts words entering the FIFO; the LEN-th one is tagged.
    assign push_last = (delivered == LEN_C - 1'b1);

    assign o_valid   = !fifo_empty;
    assign o_data    = fifo_empty ? '0 : fifo_head[DATA_WIDTH-1:0];
    assign o_last    = !fifo_empty && fifo_head[DATA_WIDTH];
    assign o_busy    = (state != ST_IDLE);
    assign handshake = o_valid && i_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            issued    <= '0;
            delivered <= '0;
            inflight  <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            inflight <= issue;
            o_done   <= 1'b0;
            if (issue)
                issued <= issued + 1'b1;
            if (inflight)
                delivered <= delivered + 1'b1;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state     <= ST_FETCH;
                        issued    <= '0;
                        delivered <= '0;
                    end
                end
                ST_FETCH: begin
                    if (issued == LEN_C)
                        state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (handshake && o_last) begin
                        state  <= ST_IDLE;
                        o_done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    lstm_sync_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .wdata ({push_last, i_mem_rdata}),
        .pop   (handshake),
        .rdata (fifo_head),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule
